// File: rtl/grf_multiport_pkg.sv
// Shared constants for the multiport general register file.
// This package holds the default geometry and the index of the hardwired zero register.
package grf_multiport_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_REG   = 0;

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// An issue sets the bit, a committed write clears it, and reset zeroes every bit.
module grf_scoreboard
    import grf_multiport_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = 2,
    parameter int NWR    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NWR-1:0]        clr_en,
    input  logic [NWR*ADDR_W-1:0] clr_addr,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD-1:0]        rd_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0]  busy;
    logic [ADDR_W-1:0] idx;
    logic              cleared;
    logic              reissued;

    // The issue is applied after the clears so that a colliding issue leaves the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (clr_en[p]) begin
                    busy[clr_addr[p*ADDR_W +: ADDR_W]] <= 1'b0;
                end
            end
            if (iss_en && (iss_addr != ZERO_IDX)) begin
                busy[iss_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_busy  = '0;
        idx      = '0;
        cleared  = 1'b0;
        reissued = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            idx     = rd_addr[k*ADDR_W +: ADDR_W];
            cleared = 1'b0;
            for (int p = 0; p < NWR; p++) begin
                if (clr_en[p] && (clr_addr[p*ADDR_W +: ADDR_W] == idx)) begin
                    cleared = 1'b1;
                end
            end
            reissued   = iss_en && (iss_addr == idx);
            rd_busy[k] = !reset && busy[idx] && !(cleared && !reissued);
        end
    end

endmodule

// File: rtl/grf_multiport.sv
// Multiport general register file with a hardwired zero register and write-through bypass.
// It also keeps a count of committed writes; the busy tracking lives in grf_scoreboard.
module grf_multiport
    import grf_multiport_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = 2,
    parameter int NWR    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic [31:0]           wr_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(NWR + 1);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [DEPTH] = '{default: '0};
    logic [NWR-1:0]    we_eff;
    logic [CNT_W-1:0]  n_writes;
    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] rd_val;

    // A write is effective only if it targets a nonzero index, reset is low, and no
    // higher-numbered port writes the same index; that makes duplicates count once.
    always_comb begin
        we_eff   = '0;
        n_writes = '0;
        for (int p = 0; p < NWR; p++) begin
            we_eff[p] = wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != ZERO_IDX) && !reset;
            for (int q = p + 1; q < NWR; q++) begin
                if (wr_en[q] && (wr_addr[q*ADDR_W +: ADDR_W] == wr_addr[p*ADDR_W +: ADDR_W])) begin
                    we_eff[p] = 1'b0;
                end
            end
            if (we_eff[p]) begin
                n_writes = n_writes + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (we_eff[p]) begin
                    regs[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
                end
            end
            wr_count <= wr_count + 32'(n_writes);
        end
    end

    // we_eff already drops reset-cycle writes, so bypass is suppressed during reset for free.
    always_comb begin
        rd_data = '0;
        rd_idx  = '0;
        rd_val  = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_idx = rd_addr[k*ADDR_W +: ADDR_W];
            rd_val = regs[rd_idx];
            for (int p = 0; p < NWR; p++) begin
                if (we_eff[p] && (wr_addr[p*ADDR_W +: ADDR_W] == rd_idx)) begin
                    rd_val = wr_data[p*DATA_W +: DATA_W];
                end
            end
            if (rd_idx == ZERO_IDX) begin
                rd_val = '0;
            end
            rd_data[k*DATA_W +: DATA_W] = rd_val;
        end
    end

    grf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NRD    (NRD),
        .NWR    (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .clr_en   (we_eff),
        .clr_addr (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_grf_multiport.sv
// Self-checking bench for grf_multiport: directed scenarios followed by random traffic,
// all compared against an array-based reference model of the register file rules.
module tb_grf_multiport;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic [31:0]      wr_count;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_regs [32];
    logic          model_busy [32];
    logic [31:0]   model_count;

    always #5 clk = ~clk;

    grf_multiport #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NRD    (NR),
        .NWR    (NW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_count (wr_count)
    );

    function automatic logic [AW-1:0] waddr(input int p);
        return wr_addr[p*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] wdata(input int p);
        return wr_data[p*DW +: DW];
    endfunction

    // Reference view: zero register reads 0; otherwise the last enabled port writing the
    // index supplies the value (unless in reset), else the stored value.
    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = model_regs[a];
        if (!reset) begin
            for (int p = 0; p < NW; p++) begin
                if (wr_en[p] && waddr(p) == a) v = wdata(p);
            end
        end
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic written;
        if (reset || a == 0) return 1'b0;
        written = 1'b0;
        for (int p = 0; p < NW; p++) begin
            if (wr_en[p] && waddr(p) == a) written = 1'b1;
        end
        if (written && !(iss_en && iss_addr == a)) return 1'b0;
        return model_busy[a];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < NR; k++) begin
            check_output($sformatf("%s_data%0d", tag, k), rd_data[k*DW +: DW], exp_data(rd_addr[k*AW +: AW]));
            check_output($sformatf("%s_busy%0d", tag, k), 32'(rd_busy[k]), 32'(exp_busy(rd_addr[k*AW +: AW])));
        end
        check_output($sformatf("%s_count", tag), wr_count, model_count);
    endtask

    // Drive one cycle of inputs away from the rising edge, then compare combinational outputs.
    task automatic apply_stimulus(input logic rst, input logic [1:0] we,
                                  input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                                  input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                                  input logic ie, input logic [AW-1:0] ia,
                                  input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                                  input string tag);
        @(negedge clk);
        reset    = rst;
        wr_en    = we;
        wr_addr  = {wa1, wa0};
        wr_data  = {wd1, wd0};
        iss_en   = ie;
        iss_addr = ia;
        rd_addr  = {ra1, ra0};
        #1;
        check_model(tag);
    endtask

    // Advance to the rising edge and apply the architectural rules to the model.
    task automatic commit;
        int n;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                model_regs[i] = '0;
                model_busy[i] = 1'b0;
            end
            model_count = '0;
        end else begin
            n = 0;
            if (wr_en[0] && waddr(0) != 0) n++;
            if (wr_en[1] && waddr(1) != 0 && !(wr_en[0] && waddr(0) == waddr(1))) n++;
            model_count = model_count + 32'(n);
            for (int p = 0; p < NW; p++) begin
                if (wr_en[p] && waddr(p) != 0) begin
                    model_regs[waddr(p)] = wdata(p);
                    model_busy[waddr(p)] = 1'b0;
                end
            end
            if (iss_en && iss_addr != 0) model_busy[iss_addr] = 1'b1;
        end
    endtask

    initial begin
        logic [AW-1:0] ra0, ra1, wa0, wa1, ia;
        for (int i = 0; i < 32; i++) begin
            model_regs[i] = '0;
            model_busy[i] = 1'b0;
        end
        model_count = '0;
        reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; rd_addr = '0;

        apply_stimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, "rst0"); commit;
        apply_stimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 3, 9, "rst1"); commit;
        apply_stimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 9, "idle");
        check_output("reset_count", wr_count, 32'd0);
        check_output("reset_data", rd_data[31:0], 32'd0);
        commit;

        apply_stimulus(0, 2'b01, 3, 32'h1234_5678, 0, 0, 0, 0, 1, 2, "w3"); commit;
        apply_stimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0, "r3");
        check_output("r3_value", rd_data[31:0], 32'h1234_5678);
        check_output("r3_count", wr_count, 32'd1);
        commit;

        apply_stimulus(0, 2'b01, 7, 32'hDEAD_BEEF, 0, 0, 0, 0, 7, 3, "byp7");
        check_output("byp7_value", rd_data[31:0], 32'hDEAD_BEEF);
        commit;

        apply_stimulus(0, 2'b11, 5, 32'h1, 5, 32'h2, 0, 0, 5, 0, "dup5");
        check_output("dup5_bypass", rd_data[31:0], 32'h2);
        commit;
        apply_stimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 7, "r5");
        check_output("r5_value", rd_data[31:0], 32'h2);
        check_output("r5_count", wr_count, 32'd3);
        commit;

        apply_stimulus(0, 2'b01, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0, "z0");
        check_output("z0_data", rd_data[31:0], 32'd0);
        check_output("z0_busy", 32'(rd_busy[0]), 32'd0);
        commit;
        apply_stimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5, "z0b");
        check_output("z0_count", wr_count, 32'd3);
        commit;

        apply_stimulus(0, 2'b00, 0, 0, 0, 0, 1, 9, 9, 0, "iss9"); commit;
        apply_stimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0, "busy9");
        check_output("busy9_set", 32'(rd_busy[0]), 32'd1);
        commit;
        apply_stimulus(0, 2'b01, 9, 32'hA5, 0, 0, 0, 0, 9, 9, "clr9");
        check_output("clr9_busy", 32'(rd_busy[0]), 32'd0);
        check_output("clr9_data", rd_data[31:0], 32'hA5);
        commit;
        apply_stimulus(0, 2'b01, 9, 32'hA5, 0, 0, 1, 9, 9, 0, "isw9"); commit;
        apply_stimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 0, "after9");
        check_output("after9_busy", 32'(rd_busy[0]), 32'd1);
        check_output("after9_data", rd_data[31:0], 32'hA5);
        check_output("after9_count", wr_count, 32'd5);
        commit;

        apply_stimulus(0, 2'b11, 1, 32'h11, 2, 32'h22, 1, 6, 1, 2, "pre"); commit;
        apply_stimulus(1, 2'b01, 4, 32'h55, 0, 0, 1, 8, 4, 1, "rstw");
        check_output("rstw_busy", 32'(rd_busy), 32'd0);
        commit;
        apply_stimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 6, "post");
        check_output("post_data4", rd_data[31:0], 32'd0);
        check_output("post_busy6", 32'(rd_busy[1]), 32'd0);
        check_output("post_count", wr_count, 32'd0);
        commit;

        for (int c = 0; c < 400; c++) begin
            wa0 = AW'($urandom_range(0, 7));
            wa1 = AW'($urandom_range(0, 7));
            ia  = AW'($urandom_range(0, 7));
            ra0 = AW'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 3) == 0) ? wa1 : AW'($urandom_range(0, 31));
            apply_stimulus(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
                           wa0, $urandom, wa1, $urandom,
                           1'($urandom_range(0, 1)), ia, ra0, ra1, "rand");
            commit;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grf_multiport.md
GRF_MULTIPORT -- requirements
Module: grf_multiport

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; depth = 2^ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2, number of write ports (1..2).
REQ-005 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port rd_addr  input  NRD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data  output  NRD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port rd_busy  output  NRD  per read port, register has an outstanding issued write.
REQ-010 SHALL have port wr_en  input  NWR  per write-port enable.
REQ-011 SHALL have port wr_addr  input  NWR*ADDR_W  write indices.
REQ-012 SHALL have port wr_data  input  NWR*DATA_W  write data.
REQ-013 SHALL have port iss_en  input  1  mark a destination register pending (scoreboard set).
REQ-014 SHALL have port iss_addr  input  ADDR_W  destination index being issued.
REQ-015 SHALL have port wr_count  output  32  number of committed (non-discarded) register writes since reset.

Function
REQ-016 Storage SHALL be 2^ADDR_W registers of DATA_W bits, plus one busy bit per register.
REQ-017 Register 0 SHALL always read 0 and never read busy; writes and issues to index 0 are discarded.
REQ-018 Read SHALL be combinational, zero latency, from all NRD ports independently.
REQ-019 Write-through bypass: a read whose index matches an enabled same-cycle write to a nonzero index SHALL return that wr_data.
REQ-020 At the rising edge, each enabled write to a nonzero index SHALL update that register and clear its busy bit.
REQ-021 Two enabled writes to the same nonzero index: the higher-numbered port SHALL win for storage and bypass; only one write is counted.
REQ-022 iss_en to a nonzero index SHALL set its busy bit at the edge.
REQ-023 Same-cycle iss_en and write to the same index: storage SHALL update and busy SHALL end set (issue wins).
REQ-024 rd_busy[k] SHALL reflect the registered busy bit, except SHALL be 0 when a same-cycle write clears that index without a colliding issue.
REQ-025 wr_count SHALL increment by the number of distinct nonzero indices written per cycle (0, 1 or 2) and wrap modulo 2^32.

Reset
REQ-026 While reset is high at a rising edge, all registers SHALL become 0, all busy bits 0, wr_count 0.
REQ-027 Reset SHALL take priority over simultaneous writes and issues, which are discarded.
REQ-028 Bypass SHALL be suppressed while reset is high: rd_data returns stored values and rd_busy is 0.
REQ-029 Storage SHALL also power up to 0 for simulation.

Structure
REQ-030 A shared package SHALL hold default DATA_W/ADDR_W constants and the index-0 (ZERO_REG) constant.
REQ-031 One sub-module grf_scoreboard SHALL own the busy bits (set on issue, clear on write, reset); the data array, bypass and counter stay in the top.

Verification
REQ-032 Reset, write port0 idx 3 = 0x1234_5678, next cycle read idx 3 -> rd_data 0x1234_5678, wr_count 1.
REQ-033 Same-cycle write idx 7 = 0xDEAD_BEEF and read idx 7 -> rd_data 0xDEAD_BEEF in that cycle (bypass).
REQ-034 Both ports write idx 5, port0 = 0x1, port1 = 0x2 -> idx 5 holds 0x2, wr_count +1.
REQ-035 Write idx 0 = 0xFFFF_FFFF with iss_en idx 0 -> rd_data 0, rd_busy 0, wr_count unchanged.
REQ-036 iss_en idx 9, then read idx 9 -> rd_busy 1; write idx 9 = 0xA5 -> rd_busy 0 that cycle; simultaneous iss+write idx 9 -> busy stays 1, data 0xA5.
REQ-037 Write several registers, assert reset with concurrent write idx 4 = 0x55 -> all reads 0, busy 0, wr_count 0.
